// File: rtl/eq_pkg.sv
// Shared types and constants for the eq detector pattern generator.
package eq_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDrive  = 2'd1,
        StFinish = 2'd2
    } state_e;

    localparam int unsigned NUM_STEPS = 4;
    localparam int unsigned STEP_W    = 2;

    // Expected eq output per step, where step = {x, y}: only 00 and 11 are equal.
    localparam logic [NUM_STEPS-1:0] EQ_EXPECT = 4'b1001;

endpackage

// File: rtl/hold_timer.sv
// 8-bit hold counter with synchronous clear; flags the sample point and the
// last cycle of each hold window.
module hold_timer #(
    parameter int unsigned HOLD_CYCLES = 50,
    parameter int unsigned SAMPLE_AT   = HOLD_CYCLES - 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic at_sample,
    output logic at_end
);

    logic [7:0] hold_q;

    // Clear wins over increment so the step advance restarts the window at 0.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hold_q <= 8'd0;
        end else if (en) begin
            hold_q <= hold_q + 8'd1;
        end
    end

    assign at_sample = (hold_q == 8'(SAMPLE_AT));
    assign at_end    = (hold_q == 8'(HOLD_CYCLES - 1));

endmodule

// File: rtl/eq_pattern_gen.sv
// Hardware self-check for the one-bit eq detector: sweeps all four (x, y)
// pairs, samples s_in once per window and reports mismatches.
module eq_pattern_gen
    import eq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 50,
    parameter int unsigned SAMPLE_AT   = HOLD_CYCLES - 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       s_in,
    output logic       x,
    output logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] err_mask
);

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                x_q, x_d, y_q, y_d;
    logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [2:0]          err_count_q, err_count_d;
    logic [3:0]          err_mask_q, err_mask_d;
    logic                timer_clear, timer_en, at_sample, at_end;

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .SAMPLE_AT   (SAMPLE_AT)
    ) u_hold_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (timer_clear),
        .en        (timer_en),
        .at_sample (at_sample),
        .at_end    (at_end)
    );

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        x_d         = x_q;
        y_d         = y_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        err_mask_d  = err_mask_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;

        unique case (state_q)
            StIdle: begin
                x_d    = 1'b0;
                y_d    = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    state_d     = StDrive;
                    step_d      = '0;
                    timer_clear = 1'b1;
                    err_count_d = 3'd0;
                    err_mask_d  = 4'd0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            StDrive: begin
                timer_en = 1'b1;
                if (at_sample && (s_in != EQ_EXPECT[step_q])) begin
                    err_count_d         = err_count_q + 3'd1;
                    err_mask_d[step_q]  = 1'b1;
                end
                if (at_end) begin
                    timer_clear = 1'b1;
                    if (step_q != 2'(NUM_STEPS - 1)) begin
                        step_d     = step_q + 2'd1;
                        {x_d, y_d} = step_q + 2'd1;
                    end else begin
                        // Uses err_count_d so a mismatch on the final sample counts.
                        state_d = StFinish;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        x_d     = 1'b0;
                        y_d     = 1'b0;
                        pass_d  = (err_count_d == 3'd0);
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            step_q      <= '0;
            x_q         <= 1'b0;
            y_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= 3'd0;
            err_mask_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            x_q         <= x_d;
            y_q         <= y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            err_mask_q  <= err_mask_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign err_mask  = err_mask_q;

endmodule

// File: tb/tb_eq_pattern_gen.sv
// Directed bench for eq_pattern_gen with HOLD_CYCLES=4; a second instance
// with SAMPLE_AT=1 checks single-point sampling.
module tb_eq_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, start_b, s_in, s_in_b;
    int         mode;  // 0: correct eq, 1: stuck-at-1, 2: inverted
    logic       x, y, busy, done, pass;
    logic [2:0] err_count;
    logic [3:0] err_mask;
    logic       x_b, y_b, busy_b, done_b, pass_b;
    logic [2:0] err_count_b;
    logic [3:0] err_mask_b;

    int checks = 0;
    int passed = 0;

    assign s_in = (mode == 0) ? ~(x ^ y) : (mode == 1) ? 1'b1 : (x ^ y);

    eq_pattern_gen #(.HOLD_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .s_in(s_in), .x(x), .y(y),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .err_mask(err_mask)
    );

    eq_pattern_gen #(.HOLD_CYCLES(4), .SAMPLE_AT(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .s_in(s_in_b), .x(x_b), .y(y_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_count_b),
        .err_mask(err_mask_b)
    );

    // Runs one sweep on dut and records timing; cycle k is the k-th cycle after
    // the edge that accepted start.
    task automatic do_sweep(input bit inj, output int done_cyc, output int busy_cyc,
                            output int done_cnt, output bit xy_ok);
        done_cyc = -1; busy_cyc = 0; done_cnt = 0; xy_ok = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cyc++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (k <= 16 && {x, y} !== 2'((k - 1) / 4)) xy_ok = 1'b0;
            if (k > 16 && {x, y} !== 2'b00) xy_ok = 1'b0;
            start = inj && (k == 3 || k == 10);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_b = 1'b0; s_in_b = 1'b0; mode = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({x, y} !== 2'b00) $display("FAIL reset_xy got %b want 00", {x, y}); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        checks++; if (pass !== 1'b0) $display("FAIL reset_pass got %b want 0", pass); else passed++;
        checks++; if (err_count !== 3'd0) $display("FAIL reset_cnt got %0d want 0", err_count); else passed++;
        checks++; if (err_mask !== 4'd0) $display("FAIL reset_mask got %b want 0000", err_mask); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_correct_eq();
        int dc, bc, dn; bit ok;
        mode = 0;
        do_sweep(1'b0, dc, bc, dn, ok);
        checks++; if (dc !== 17) $display("FAIL correct_done_cycle got %0d want 17", dc); else passed++;
        checks++; if (bc !== 16) $display("FAIL correct_busy_cycles got %0d want 16", bc); else passed++;
        checks++; if (dn !== 1) $display("FAIL correct_done_count got %0d want 1", dn); else passed++;
        checks++; if (ok !== 1'b1) $display("FAIL correct_xy_sequence got %b want 1", ok); else passed++;
        checks++; if (err_count !== 3'd0) $display("FAIL correct_cnt got %0d want 0", err_count); else passed++;
        checks++; if (err_mask !== 4'b0000) $display("FAIL correct_mask got %b want 0000", err_mask); else passed++;
        checks++; if (pass !== 1'b1) $display("FAIL correct_pass got %b want 1", pass); else passed++;
    endtask

    task automatic test_stuck_at_one();
        int dc, bc, dn; bit ok;
        mode = 1;
        do_sweep(1'b0, dc, bc, dn, ok);
        checks++; if (err_count !== 3'd2) $display("FAIL stuck_cnt got %0d want 2", err_count); else passed++;
        checks++; if (err_mask !== 4'b0110) $display("FAIL stuck_mask got %b want 0110", err_mask); else passed++;
        checks++; if (pass !== 1'b0) $display("FAIL stuck_pass got %b want 0", pass); else passed++;
        checks++; if (dn !== 1) $display("FAIL stuck_done_count got %0d want 1", dn); else passed++;
    endtask

    task automatic test_inverted();
        int dc, bc, dn; bit ok;
        mode = 2;
        do_sweep(1'b0, dc, bc, dn, ok);
        checks++; if (err_count !== 3'd4) $display("FAIL inv_cnt got %0d want 4", err_count); else passed++;
        checks++; if (err_mask !== 4'b1111) $display("FAIL inv_mask got %b want 1111", err_mask); else passed++;
        checks++; if (pass !== 1'b0) $display("FAIL inv_pass got %b want 0", pass); else passed++;
        mode = 0;
        do_sweep(1'b0, dc, bc, dn, ok);
        checks++; if (err_count !== 3'd0) $display("FAIL rerun_cnt got %0d want 0", err_count); else passed++;
        checks++; if (err_mask !== 4'b0000) $display("FAIL rerun_mask got %b want 0000", err_mask); else passed++;
        checks++; if (pass !== 1'b1) $display("FAIL rerun_pass got %b want 1", pass); else passed++;
    endtask

    task automatic test_start_ignored();
        int dc, bc, dn; bit ok;
        mode = 0;
        do_sweep(1'b1, dc, bc, dn, ok);
        checks++; if (dn !== 1) $display("FAIL ignore_done_count got %0d want 1", dn); else passed++;
        checks++; if (dc !== 17) $display("FAIL ignore_done_cycle got %0d want 17", dc); else passed++;
        checks++; if (bc !== 16) $display("FAIL ignore_busy_cycles got %0d want 16", bc); else passed++;
        checks++; if (ok !== 1'b1) $display("FAIL ignore_xy_sequence got %b want 1", ok); else passed++;
    endtask

    task automatic test_reset_mid_sweep();
        int dn;
        mode = 1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        checks++; if ({x, y} !== 2'b10) $display("FAIL midrst_pre_xy got %b want 10", {x, y}); else passed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({x, y} !== 2'b00) $display("FAIL midrst_xy got %b want 00", {x, y}); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passed++;
        checks++; if (err_count !== 3'd0) $display("FAIL midrst_cnt got %0d want 0", err_count); else passed++;
        checks++; if (err_mask !== 4'd0) $display("FAIL midrst_mask got %b want 0000", err_mask); else passed++;
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dn++;
        end
        checks++; if (dn !== 0) $display("FAIL midrst_activity got %0d want 0", dn); else passed++;
    endtask

    task automatic test_sample_timing();
        int dn;
        bit exp_s;
        dn = 0;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (done_b === 1'b1) dn++;
            if (k <= 16) begin
                exp_s = ((k - 1) / 4 == 0) || ((k - 1) / 4 == 3);
                s_in_b = (((k - 1) % 4) >= 2) ? ~exp_s : exp_s;
            end else begin
                s_in_b = 1'b0;
            end
        end
        checks++; if (dn !== 1) $display("FAIL sample_done_count got %0d want 1", dn); else passed++;
        checks++; if (err_count_b !== 3'd0) $display("FAIL sample_cnt got %0d want 0", err_count_b); else passed++;
        checks++; if (err_mask_b !== 4'd0) $display("FAIL sample_mask got %b want 0000", err_mask_b); else passed++;
        checks++; if (pass_b !== 1'b1) $display("FAIL sample_pass got %b want 1", pass_b); else passed++;
    endtask

    initial begin
        test_reset();
        test_correct_eq();
        test_stuck_at_one();
        test_inverted();
        test_start_ignored();
        test_reset_mid_sweep();
        test_sample_timing();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
